// File: rtl/div_ctrl.sv
// Divide-unit controller: sign handling around an external unsigned divider,
// with divider warm-up after reset, divide-by-zero bypass and flush draining.
module div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        div_divisor_tvalid,
  output logic        div_dividend_tvalid,
  output logic [31:0] div_divisor_tdata,
  output logic [31:0] div_dividend_tdata,
  input  logic        div_dout_tvalid,
  input  logic [63:0] div_dout_tdata
);

  typedef enum logic [2:0] {RST_WAIT, IDLE, WAIT, DONE, DRAIN} state_t;

  state_t      state;
  logic [5:0]  rst_cnt;
  logic [1:0]  op_q;
  logic        s1_q;
  logic        s2_q;
  logic        issue;

  logic        s1_in;
  logic        s2_in;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [31:0] q_raw;
  logic [31:0] r_raw;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] fix_res;

  assign in_ready            = (state == IDLE) && !flush;
  assign div_divisor_tvalid  = issue;
  assign div_dividend_tvalid = issue;

  always_comb begin
    // Signs are only meaningful for the signed ops (op[1] == 0).
    s1_in = ~op[1] & src1[31];
    s2_in = ~op[1] & src2[31];
    mag1  = s1_in ? (~src1 + 32'd1) : src1;
    mag2  = s2_in ? (~src2 + 32'd1) : src2;
    q_raw = div_dout_tdata[63:32];
    r_raw = div_dout_tdata[31:0];
    q_fix = (s1_q ^ s2_q) ? (~q_raw + 32'd1) : q_raw;
    r_fix = s1_q ? (~r_raw + 32'd1) : r_raw;
    fix_res = op_q[0] ? r_fix : q_fix;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= RST_WAIT;
      rst_cnt            <= '0;
      out_valid          <= 1'b0;
      out_result         <= '0;
      issue              <= 1'b0;
      div_divisor_tdata  <= '0;
      div_dividend_tdata <= '0;
      op_q               <= '0;
      s1_q               <= 1'b0;
      s2_q               <= 1'b0;
    end else begin
      issue <= 1'b0;
      case (state)
        RST_WAIT: begin
          if (rst_cnt == 6'd33) state <= IDLE;
          else                  rst_cnt <= rst_cnt + 6'd1;
        end
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q <= op;
            s1_q <= s1_in;
            s2_q <= s2_in;
            if (src2 == '0) begin
              out_result <= op[0] ? src1 : '1;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              issue              <= 1'b1;
              div_dividend_tdata <= mag1;
              div_divisor_tdata  <= mag2;
              state              <= WAIT;
            end
          end
        end
        WAIT: begin
          // A result arriving with the flush is already consumed, so no drain.
          if (flush) begin
            state <= div_dout_tvalid ? IDLE : DRAIN;
          end else if (div_dout_tvalid) begin
            out_result <= fix_res;
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (flush || out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        DRAIN: begin
          if (div_dout_tvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous, active-high.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 in_valid  in  1  EX stage presents a divide op.
REQ-005 in_ready  out  1  op accepted when in_valid&&in_ready.
REQ-006 op  in  2  00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu.
REQ-007 src1  in  32  dividend.
REQ-008 src2  in  32  divisor.
REQ-009 flush  in  1  cancel current op (exception/branch flush).
REQ-010 out_valid  out  1  out_result valid.
REQ-011 out_ready  in  1  consumer takes result when out_valid&&out_ready.
REQ-012 out_result  out  32  quotient or remainder, per op.
REQ-013 div_divisor_tvalid / div_dividend_tvalid  out  1 each  issue strobes to unsigned divider; always driven identically.
REQ-014 div_divisor_tdata / div_dividend_tdata  out  32 each  unsigned operands.
REQ-015 div_dout_tvalid  in  1  divider result strobe, one cycle.
REQ-016 div_dout_tdata  in  64  [63:32] unsigned quotient, [31:0] unsigned remainder.

Function
REQ-017 States: RST_WAIT, IDLE, WAIT, DONE, DRAIN; in_ready=1 only in IDLE with flush=0.
REQ-018 RST_WAIT: 6-bit counter runs 34 cycles after reset release, then IDLE; div_dout_tvalid ignored (divider has no reset, may emit stale result).
REQ-019 Accept in IDLE: latch op, sign of src1 (s1), sign of src2 (s2); signed ops drive magnitudes |src1|,|src2| (two's-complement negate if negative), unsigned ops drive raw values.
REQ-020 Issue: both tvalids high exactly one cycle (cycle after accept, registered), tdata held stable that cycle; next state WAIT.
REQ-021 Divide-by-zero (src2==0): no issue; next state DONE directly; quotient 0xFFFFFFFF, remainder src1 (raw, all ops).
REQ-022 WAIT: on div_dout_tvalid capture result, apply sign fix, go DONE; out_valid rises the next cycle (registered).
REQ-023 Sign fix (signed ops only): quotient negated if s1^s2, remainder negated if s1; 32-bit wrap, so 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-024 DONE: out_valid=1, out_result stable until out_valid&&out_ready, then IDLE; no new accept in same cycle.
REQ-025 flush in IDLE: no accept. In WAIT: go DRAIN (or IDLE if div_dout_tvalid same cycle), no out_valid. In DONE: out_valid drops next cycle, IDLE.
REQ-026 DRAIN: in_ready=0; on div_dout_tvalid discard data, go IDLE; flush in DRAIN has no effect.
REQ-027 div_dout_tvalid outside WAIT/DRAIN ignored.
REQ-028 Latency accept->out_valid = divider latency + 2 cycles (32-cycle divider: 34); div-by-zero: 1 cycle.

Reset
REQ-029 On reset: state RST_WAIT, counter 0, out_valid 0, out_result 0, both tvalids 0, tdata 0, in_ready 0.
REQ-030 Reset mid-operation aborts immediately; any late div_dout_tvalid falls inside RST_WAIT and is discarded.

Verification
REQ-031 div.w -7/2 -> out_result 0xFFFFFFFD; mod.w -7/2 -> 0xFFFFFFFF; div.w 7/-2 -> 0xFFFFFFFD, mod.w -> 0x00000001.
REQ-032 div.wu 0xFFFFFFFF/0x10 -> 0x0FFFFFFF; mod.wu -> 0x0000000F; divider saw raw operands.
REQ-033 div.w 0x80000000/0xFFFFFFFF -> 0x80000000; mod.w -> 0x00000000.
REQ-034 div.w 5/0 -> 0xFFFFFFFF one cycle after accept, tvalids never asserted; mod.w 5/0 -> 0x00000005.
REQ-035 Flush 10 cycles into WAIT -> DRAIN, in_ready 0 until div_dout_tvalid, no out_valid; next op div.wu 100/7 -> 14.
REQ-036 out_ready low 5 cycles in DONE -> out_result stable, out_valid held; reset release -> in_ready 0 for 34 cycles, injected div_dout_tvalid ignored.
